// File: rtl/video_card.sv
// Blitter engine: fetches a 4-word descriptor from RAM, then FILLs or COPYs a word region
// and writes a completion status word back into the descriptor.
module video_card #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] CMD_BASE     = '0,
  parameter int unsigned      READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             interrupt_start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] address,
  output logic             wren,
  output logic             busy,
  output logic             done
);

  localparam int unsigned LAT = (READ_LATENCY < 1) ? 1 : READ_LATENCY;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] STATUS = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [WIDTH-1:0] OP_FILL = '0;
  localparam logic [WIDTH-1:0] OP_COPY = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] address_q, address_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             wren_q, wren_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_q, rd_d;
  logic [LAT-1:0]   vld_q, vld_d;
  logic [2:0]       issue_cnt_q, issue_cnt_d;
  logic [1:0]       cap_cnt_q, cap_cnt_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] dst_q, dst_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] idx_next;
  logic             capture;

  function automatic logic [WIDTH-1:0] status_word(input logic [WIDTH-1:0] op);
    return {1'b1, (op > OP_COPY), op[WIDTH-3:0]};
  endfunction

  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    data_out_d  = data_out_q;
    wren_d      = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_d        = 1'b0;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    op_d        = op_q;
    arg_d       = arg_q;
    dst_d       = dst_q;
    count_d     = count_q;
    idx_d       = idx_q;
    idx_next    = idx_q + ONE;
    // vld_q[k] marks a read whose data arrives k+1 cycles after its address cycle
    vld_d[0]    = rd_q;
    for (int k = 1; k < LAT; k++) begin
      vld_d[k] = vld_q[k-1];
    end
    capture = vld_q[LAT-1];

    case (state_q)
      IDLE: begin
        if (interrupt_start) begin
          state_d     = FETCH;
          address_d   = CMD_BASE;
          busy_d      = 1'b1;
          rd_d        = 1'b1;
          issue_cnt_d = 3'd1;
          cap_cnt_d   = 2'd0;
        end
      end

      FETCH: begin
        if (issue_cnt_q != 3'd4) begin
          address_d   = CMD_BASE + WIDTH'(issue_cnt_q);
          rd_d        = 1'b1;
          issue_cnt_d = issue_cnt_q + 3'd1;
        end
        if (capture) begin
          cap_cnt_d = cap_cnt_q + 2'd1;
          case (cap_cnt_q)
            2'd0: op_d  = data_in;
            2'd1: arg_d = data_in;
            2'd2: dst_d = data_in;
            default: begin
              // Word count arrives this cycle, so decide the first EXEC action from data_in
              count_d = data_in;
              idx_d   = '0;
              if ((op_q > OP_COPY) || (data_in == '0)) begin
                state_d    = STATUS;
                address_d  = CMD_BASE;
                data_out_d = status_word(op_q);
                wren_d     = 1'b1;
              end else if (op_q == OP_FILL) begin
                state_d    = EXEC;
                address_d  = dst_q;
                data_out_d = arg_q;
                wren_d     = 1'b1;
              end else begin
                state_d   = EXEC;
                address_d = arg_q;
                rd_d      = 1'b1;
              end
            end
          endcase
        end
      end

      EXEC: begin
        if (op_q == OP_FILL) begin
          if (idx_next == count_q) begin
            state_d    = STATUS;
            address_d  = CMD_BASE;
            data_out_d = status_word(op_q);
            wren_d     = 1'b1;
          end else begin
            address_d = dst_q + idx_next;
            wren_d    = 1'b1;
            idx_d     = idx_next;
          end
        end else if (capture) begin
          address_d  = dst_q + idx_q;
          data_out_d = data_in;
          wren_d     = 1'b1;
        end else if (wren_q) begin
          // Next read is issued only after the previous write, keeping forward replication
          if (idx_next == count_q) begin
            state_d    = STATUS;
            address_d  = CMD_BASE;
            data_out_d = status_word(op_q);
            wren_d     = 1'b1;
          end else begin
            address_d = arg_q + idx_next;
            rd_d      = 1'b1;
            idx_d     = idx_next;
          end
        end
      end

      STATUS: begin
        state_d = DONE;
        done_d  = 1'b1;
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      address_q   <= '0;
      data_out_q  <= '0;
      wren_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_q        <= 1'b0;
      vld_q       <= '0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      op_q        <= '0;
      arg_q       <= '0;
      dst_q       <= '0;
      count_q     <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      data_out_q  <= data_out_d;
      wren_q      <= wren_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_q        <= rd_d;
      vld_q       <= vld_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      op_q        <= op_d;
      arg_q       <= arg_d;
      dst_q       <= dst_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
    end
  end

  assign address  = address_q;
  assign data_out = data_out_q;
  assign wren     = wren_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_video_card.sv
// Bench for video_card: synchronous-read RAM model, expected RAM writes queued per job and
// compared in order against the writes the DUT issues.
module tb_video_card;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        interrupt_start = 1'b0;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [31:0] address;
  logic        wren;
  logic        busy;
  logic        done;

  video_card #(
    .WIDTH       (32),
    .CMD_BASE    (32'h0),
    .READ_LATENCY(1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .interrupt_start(interrupt_start),
    .data_in        (data_in),
    .data_out       (data_out),
    .address        (address),
    .wren           (wren),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // RAM model, 256 words aliased on address[7:0], one cycle read latency
  logic [31:0] mem [256];
  logic [31:0] ram_q = 32'h0;
  logic        poke_en = 1'b0;
  logic [7:0]  poke_addr = 8'h0;
  logic [31:0] poke_data = 32'h0;
  assign data_in = ram_q;

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (wren) mem[address[7:0]] <= data_out;
    ram_q <= mem[address[7:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e;
  logic [31:0] obs_addr [64];
  logic [31:0] obs_data [64];
  int          obs_cyc  [64];
  int          obs_n;
  int          dones;
  int          done_cyc;
  int          checks = 0;
  int          failures = 0;
  bit          to;

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    poke_en   = 1'b1;
    poke_addr = a[7:0];
    poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic write_desc(input logic [31:0] op, input logic [31:0] arg,
                            input logic [31:0] dst, input logic [31:0] n);
    poke(32'h0, op);
    poke(32'h1, arg);
    poke(32'h2, dst);
    poke(32'h3, n);
  endtask

  task automatic pulse_start();
    interrupt_start = 1'b1;
    @(negedge clk);
    interrupt_start = 1'b0;
  endtask

  // Records every write and done pulse until the job is back in idle; pulse_at re-pulses start.
  task automatic run_job(input int max_cycles, input int pulse_at, output bit timed_out);
    obs_n     = 0;
    dones     = 0;
    done_cyc  = -1;
    timed_out = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      interrupt_start = (i == pulse_at);
      if (wren && obs_n < 64) begin
        obs_addr[obs_n] = address;
        obs_data[obs_n] = data_out;
        obs_cyc[obs_n]  = cyc;
        obs_n++;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (dones > 0 && !busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    interrupt_start = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b want=0", wren); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++;
    if (address !== 32'h0) begin
      failures++; $display("FAIL reset_address got=%h want=0", address);
    end
    checks++;
    if (data_out !== 32'h0) begin
      failures++; $display("FAIL reset_data_out got=%h want=0", data_out);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    write_desc(32'd0, 32'hA5A5A5A5, 32'h40, 32'd4);
    for (int k = 0; k < 4; k++) exp_q.push_back({32'h40 + 32'(k), 32'hA5A5A5A5});
    exp_q.push_back({32'h0, 32'h80000000});
    pulse_start();
    checks++;
    if (busy !== 1'b1 || address !== 32'h0 || wren !== 1'b0) begin
      failures++;
      $display("FAIL fill_accept got busy=%b addr=%h wren=%b want 1/0/0", busy, address, wren);
    end
    run_job(60, -1, to);
    checks++;
    if (to) begin failures++; $display("FAIL fill_timeout got no done want done"); end
    for (int k = 0; k < obs_n; k++) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL fill_extra got %h:%h want none", obs_addr[k], obs_data[k]);
      end else begin
        e = exp_q.pop_front();
        if (obs_addr[k] !== e.addr || obs_data[k] !== e.data) begin
          failures++;
          $display("FAIL fill_write%0d got %h:%h want %h:%h", k, obs_addr[k], obs_data[k],
                   e.addr, e.data);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL fill_missing got=%0d want=%0d", obs_n, obs_n + exp_q.size());
      exp_q.delete();
    end
    for (int k = 0; k + 1 < obs_n; k++) begin
      checks++;
      if (obs_cyc[k+1] - obs_cyc[k] != 1) begin
        failures++; $display("FAIL fill_gap%0d got=%0d want=1", k, obs_cyc[k+1] - obs_cyc[k]);
      end
    end
    checks++;
    if (dones != 1 || obs_n == 0 || done_cyc != obs_cyc[obs_n-1] + 1) begin
      failures++; $display("FAIL fill_done got dones=%0d cyc=%0d want 1 pulse after status",
                           dones, done_cyc);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[8'h40 + 8'(k)] !== 32'hA5A5A5A5) begin
        failures++; $display("FAIL fill_ram%0d got=%h want=a5a5a5a5", k, mem[8'h40 + 8'(k)]);
      end
    end
    checks++;
    if (mem[0] !== 32'h80000000) begin
      failures++; $display("FAIL fill_status got=%h want=80000000", mem[0]);
    end
  endtask

  task automatic test_copy();
    int gap [3] = '{3, 3, 1};
    poke(32'h20, 32'd1);
    poke(32'h21, 32'd2);
    poke(32'h22, 32'd3);
    write_desc(32'd1, 32'h20, 32'h60, 32'd3);
    for (int k = 0; k < 3; k++) exp_q.push_back({32'h60 + 32'(k), 32'(k + 1)});
    exp_q.push_back({32'h0, 32'h80000001});
    pulse_start();
    run_job(80, -1, to);
    checks++;
    if (to) begin failures++; $display("FAIL copy_timeout got no done want done"); end
    for (int k = 0; k < obs_n; k++) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL copy_extra got %h:%h want none", obs_addr[k], obs_data[k]);
      end else begin
        e = exp_q.pop_front();
        if (obs_addr[k] !== e.addr || obs_data[k] !== e.data) begin
          failures++;
          $display("FAIL copy_write%0d got %h:%h want %h:%h", k, obs_addr[k], obs_data[k],
                   e.addr, e.data);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL copy_missing got=%0d want=%0d", obs_n, obs_n + exp_q.size());
      exp_q.delete();
    end
    for (int k = 0; k + 1 < obs_n && k < 3; k++) begin
      checks++;
      if (obs_cyc[k+1] - obs_cyc[k] != gap[k]) begin
        failures++;
        $display("FAIL copy_gap%0d got=%0d want=%0d", k, obs_cyc[k+1] - obs_cyc[k], gap[k]);
      end
    end
    checks++;
    if (dones != 1) begin failures++; $display("FAIL copy_done got=%0d want=1", dones); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (mem[8'h60 + 8'(k)] !== 32'(k + 1)) begin
        failures++; $display("FAIL copy_ram%0d got=%h want=%h", k, mem[8'h60 + 8'(k)], k + 1);
      end
    end
  endtask

  task automatic test_edge_cases();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin
          poke(32'h50, 32'hDEAD0050);
          write_desc(32'd0, 32'h12345678, 32'h50, 32'd0);
          exp_q.push_back({32'h0, 32'h80000000});
        end
        1: begin
          write_desc(32'd7, 32'h11111111, 32'h50, 32'd2);
          exp_q.push_back({32'h0, 32'hC0000007});
        end
        default: begin
          write_desc(32'd0, 32'h5A5A0000, 32'hFFFFFFFF, 32'd2);
          exp_q.push_back({32'hFFFFFFFF, 32'h5A5A0000});
          exp_q.push_back({32'h0, 32'h5A5A0000});
          exp_q.push_back({32'h0, 32'h80000000});
        end
      endcase
      pulse_start();
      run_job(60, -1, to);
      checks++;
      if (to) begin failures++; $display("FAIL edge%0d_timeout got no done want done", c); end
      for (int k = 0; k < obs_n; k++) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL edge%0d_extra got %h:%h want none", c, obs_addr[k], obs_data[k]);
        end else begin
          e = exp_q.pop_front();
          if (obs_addr[k] !== e.addr || obs_data[k] !== e.data) begin
            failures++;
            $display("FAIL edge%0d_write%0d got %h:%h want %h:%h", c, k, obs_addr[k],
                     obs_data[k], e.addr, e.data);
          end
        end
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL edge%0d_missing got=%0d want=%0d", c, obs_n, obs_n + exp_q.size());
        exp_q.delete();
      end
      checks++;
      if (dones != 1) begin failures++; $display("FAIL edge%0d_done got=%0d want=1", c, dones); end
    end
    checks++;
    if (mem[8'h50] !== 32'hDEAD0050) begin
      failures++; $display("FAIL edge_untouched got=%h want=dead0050", mem[8'h50]);
    end
    checks++;
    if (mem[8'hFF] !== 32'h5A5A0000) begin
      failures++; $display("FAIL edge_wrap_ram got=%h want=5a5a0000", mem[8'hFF]);
    end
  endtask

  task automatic test_start_while_busy();
    write_desc(32'd0, 32'h11, 32'h70, 32'd4);
    for (int k = 0; k < 4; k++) exp_q.push_back({32'h70 + 32'(k), 32'h11});
    exp_q.push_back({32'h0, 32'h80000000});
    pulse_start();
    run_job(60, 4, to);
    checks++;
    if (to) begin failures++; $display("FAIL busy_timeout got no done want done"); end
    for (int k = 0; k < obs_n; k++) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL busy_extra got %h:%h want none", obs_addr[k], obs_data[k]);
      end else begin
        e = exp_q.pop_front();
        if (obs_addr[k] !== e.addr || obs_data[k] !== e.data) begin
          failures++;
          $display("FAIL busy_write%0d got %h:%h want %h:%h", k, obs_addr[k], obs_data[k],
                   e.addr, e.data);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL busy_missing got=%0d want=%0d", obs_n, obs_n + exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (dones != 1) begin failures++; $display("FAIL busy_done_count got=%0d want=1", dones); end
    // Descriptor opcode now holds the status word 0x80000000, an unknown opcode
    exp_q.push_back({32'h0, 32'hC0000000});
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got busy=%b want=1", busy); end
    run_job(60, -1, to);
    checks++;
    if (to) begin failures++; $display("FAIL b2b_timeout got no done want done"); end
    for (int k = 0; k < obs_n; k++) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL b2b_extra got %h:%h want none", obs_addr[k], obs_data[k]);
      end else begin
        e = exp_q.pop_front();
        if (obs_addr[k] !== e.addr || obs_data[k] !== e.data) begin
          failures++;
          $display("FAIL b2b_write%0d got %h:%h want %h:%h", k, obs_addr[k], obs_data[k],
                   e.addr, e.data);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL b2b_missing got=%0d want=%0d", obs_n, obs_n + exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_job();
    bit seen = 1'b0;
    int wr = 0;
    int dn = 0;
    int bz = 0;
    poke(32'h20, 32'd1);
    poke(32'h21, 32'd2);
    poke(32'h22, 32'd3);
    for (int k = 0; k < 3; k++) poke(32'h68 + 32'(k), 32'h0);
    write_desc(32'd1, 32'h20, 32'h68, 32'd3);
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wren) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL rst_first_write got none want 00000068:00000001");
    end else if (address !== 32'h68 || data_out !== 32'h1) begin
      failures++;
      $display("FAIL rst_first_write got %h:%h want 00000068:00000001", address, data_out);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (address !== 32'h0 || wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rst_async got addr=%h wren=%b busy=%b done=%b want 0/0/0/0",
               address, wren, busy, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (wren) wr++;
      if (done) dn++;
      if (busy) bz++;
    end
    checks++;
    if (wr != 0) begin failures++; $display("FAIL rst_no_writes got=%0d want=0", wr); end
    checks++;
    if (dn != 0 || bz != 0) begin
      failures++; $display("FAIL rst_idle got done=%0d busy=%0d want 0/0", dn, bz);
    end
    checks++;
    if (mem[8'h69] !== 32'h0 || mem[8'h6A] !== 32'h0) begin
      failures++; $display("FAIL rst_ram got %h %h want 0 0", mem[8'h69], mem[8'h6A]);
    end
    checks++;
    if (mem[0] !== 32'h1) begin
      failures++; $display("FAIL rst_no_status got=%h want=00000001", mem[0]);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_edge_cases();
    test_start_while_busy();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
